// File: rtl/bus_arb_ooo.sv
// Host/device interconnect with grant handshake, in-order response tracking FIFO and
// built-in decode-error responder. Define BUS_RR_ARB_EN for round-robin host arbitration.
module bus_arb_ooo #(
   parameter int unsigned NrHosts        = 2,
   parameter int unsigned NrDevices      = 2,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddressWidth   = 32,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NrHosts-1:0]                host_req_i,
   output logic [NrHosts-1:0]                host_gnt_o,
   input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]                host_we_i,
   input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
   input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
   output logic [NrHosts-1:0]                host_rvalid_o,
   output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
   output logic [NrHosts-1:0]                host_err_o,
   output logic [NrDevices-1:0]              device_req_o,
   input  logic [NrDevices-1:0]              device_gnt_i,
   output logic [NrDevices*AddressWidth-1:0] device_addr_o,
   output logic [NrDevices-1:0]              device_we_o,
   output logic [NrDevices*DataWidth/8-1:0]  device_be_o,
   output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
   input  logic [NrDevices-1:0]              device_rvalid_i,
   input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
   input  logic [NrDevices-1:0]              device_err_i,
   input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base,
   input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask,
   output logic [$clog2(MaxOutstanding):0]   outstanding_o
);
   localparam int unsigned BeWidth  = DataWidth / 8;
   localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
   localparam int unsigned PtrW     = $clog2(MaxOutstanding);
   localparam int unsigned CntW     = PtrW + 1;

   typedef struct packed {
      logic [HostIdxW-1:0] host;
      logic [DevIdxW-1:0]  dev;
      logic                miss;
   } entry_t;

   logic                    win_valid;
   logic [HostIdxW-1:0]     win;
   logic [AddressWidth-1:0] win_addr;
   logic                    hit;
   logic [DevIdxW-1:0]      sel;
   logic                    full;
   logic                    empty;
   logic                    fwd;
   logic                    accept;
   logic                    pop;
   entry_t                  head;
   entry_t                  fifo [MaxOutstanding];
   logic [PtrW-1:0]         wr_ptr;
   logic [PtrW-1:0]         rd_ptr;
   logic [CntW-1:0]         count;

`ifdef BUS_RR_ARB_EN
   logic [HostIdxW-1:0] rr_ptr;
   int unsigned         cand;

   // Search begins at rr_ptr and wraps, so the host after the last grantee has priority.
   always_comb begin
      win_valid = 1'b0;
      win       = '0;
      cand      = 0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= NrHosts) cand = cand - NrHosts;
         if (!win_valid && host_req_i[cand]) begin
            win_valid = 1'b1;
            win       = HostIdxW'(cand);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (32'(win) == NrHosts - 1) ? '0 : win + HostIdxW'(1);
      end
   end
`else
   always_comb begin
      win_valid = 1'b0;
      win       = '0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         if (!win_valid && host_req_i[i]) begin
            win_valid = 1'b1;
            win       = HostIdxW'(i);
         end
      end
   end
`endif

   assign win_addr = host_addr_i[32'(win)*AddressWidth +: AddressWidth];

   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int unsigned d = 0; d < NrDevices; d++) begin
         if (!hit && ((win_addr & cfg_device_addr_mask[d*AddressWidth +: AddressWidth]) ==
                      cfg_device_addr_base[d*AddressWidth +: AddressWidth])) begin
            hit = 1'b1;
            sel = DevIdxW'(d);
         end
      end
   end

   assign full   = (count == CntW'(MaxOutstanding));
   assign empty  = (count == '0);
   assign fwd    = rst_ni & win_valid & hit & !full;
   assign accept = rst_ni & win_valid & !full & (!hit | device_gnt_i[sel]);
   assign head   = fifo[rd_ptr];
   assign pop    = rst_ni & !empty & (head.miss | device_rvalid_i[head.dev]);

   always_comb begin
      host_gnt_o     = '0;
      device_req_o   = '0;
      device_addr_o  = '0;
      device_we_o    = '0;
      device_be_o    = '0;
      device_wdata_o = '0;
      if (accept) host_gnt_o[win] = 1'b1;
      if (fwd) begin
         device_req_o[sel]                                  = 1'b1;
         device_addr_o[32'(sel)*AddressWidth +: AddressWidth] = win_addr;
         device_we_o[sel]                                   = host_we_i[win];
         device_be_o[32'(sel)*BeWidth +: BeWidth]           = host_be_i[32'(win)*BeWidth +: BeWidth];
         device_wdata_o[32'(sel)*DataWidth +: DataWidth]    =
            host_wdata_i[32'(win)*DataWidth +: DataWidth];
      end
   end

   // Decode misses complete from the FIFO head alone; device responses only match the head's device.
   always_comb begin
      host_rvalid_o = '0;
      host_rdata_o  = '0;
      host_err_o    = '0;
      if (pop) begin
         host_rvalid_o[head.host] = 1'b1;
         if (head.miss) begin
            host_err_o[head.host] = 1'b1;
         end else begin
            host_err_o[head.host] = device_err_i[head.dev];
            host_rdata_o[32'(head.host)*DataWidth +: DataWidth] =
               device_rdata_i[32'(head.dev)*DataWidth +: DataWidth];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) fifo[wr_ptr] <= '{host: win, dev: sel, miss: !hit};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop)    rd_ptr <= rd_ptr + PtrW'(1);
         case ({accept, pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

   assign outstanding_o = count;

endmodule

// File: tb/tb_bus_arb_ooo.sv
// Self-checking bench for bus_arb_ooo: directed test-plan steps followed by random traffic,
// checked every cycle against a transaction-queue reference model.
module tb_bus_arb_ooo;
   localparam int NH = 2;
   localparam int ND = 2;
   localparam int MO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, gnt, we, rvalid, err, dreq, dgnt, dwe, drv, derr;
   logic [63:0] addr, wdata, rdata, daddr, dwdata, drdata, base, mask;
   logic [7:0]  be, dbe;
   logic [2:0]  outstanding;

   assign base = {32'h0010_0000, 32'h0000_0000};
   assign mask = {32'hFFF0_0000, 32'hFFF0_0000};

   always #5 clk = ~clk;

   bus_arb_ooo #(
      .NrHosts(2), .NrDevices(2), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_req_i(req), .host_gnt_o(gnt), .host_addr_i(addr), .host_we_i(we),
      .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rvalid), .host_rdata_o(rdata),
      .host_err_o(err),
      .device_req_o(dreq), .device_gnt_i(dgnt), .device_addr_o(daddr), .device_we_o(dwe),
      .device_be_o(dbe), .device_wdata_o(dwdata), .device_rvalid_i(drv),
      .device_rdata_i(drdata), .device_err_i(derr),
      .cfg_device_addr_base(base), .cfg_device_addr_mask(mask),
      .outstanding_o(outstanding)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      int host;
      int dev;
      bit miss;
   } ent_t;
   ent_t q[$];
`ifdef BUS_RR_ARB_EN
   int m_ptr = 0;
`endif

   logic [1:0] s_gnt, s_rv, s_err, s_dreq;
   logic [63:0] s_rdata;
   logic [2:0] s_out;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int decode(input logic [31:0] a);
      for (int d = 0; d < ND; d++)
         if ((a & mask[d*32 +: 32]) == base[d*32 +: 32]) return d;
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
`ifdef BUS_RR_ARB_EN
      m_ptr = 0;
`endif
   endtask

   task automatic idle();
      req = '0; addr = '0; we = '0; be = '0; wdata = '0;
      dgnt = '0; drv = '0; drdata = '0; derr = '0;
   endtask

   task automatic host_set(input int h, input logic [31:0] a, input bit w,
                           input logic [3:0] b, input logic [31:0] d);
      req[h] = 1'b1;
      addr[h*32 +: 32] = a;
      we[h] = w;
      be[h*4 +: 4] = b;
      wdata[h*32 +: 32] = d;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_gnt"}, gnt, 0);
      chk({p, "_rvalid"}, rvalid, 0);
      chk({p, "_rdata"}, rdata, 0);
      chk({p, "_err"}, err, 0);
      chk({p, "_dreq"}, dreq, 0);
      chk({p, "_daddr"}, daddr, 0);
      chk({p, "_dwe"}, dwe, 0);
      chk({p, "_dbe"}, dbe, 0);
      chk({p, "_dwdata"}, dwdata, 0);
      chk({p, "_outstanding"}, outstanding, 0);
   endtask

   // One clock cycle: predict outputs from the transaction queue, compare, then retire/enqueue.
   task automatic cycle();
      logic [1:0]  e_gnt, e_rv, e_err, e_dreq, e_dwe;
      logic [63:0] e_rdata, e_daddr, e_dwdata;
      logic [7:0]  e_dbe;
      int w, sel;
      bit popped;
      ent_t ent, nent;
      @(negedge clk);
      e_gnt = '0; e_rv = '0; e_err = '0; e_dreq = '0; e_dwe = '0;
      e_rdata = '0; e_daddr = '0; e_dwdata = '0; e_dbe = '0;
      w = -1; sel = -1; popped = 1'b0;
      for (int k = 0; k < NH; k++) begin
         int h;
`ifdef BUS_RR_ARB_EN
         h = (m_ptr + k) % NH;
`else
         h = k;
`endif
         if (w < 0 && req[h]) w = h;
      end
      if (w >= 0) begin
         sel = decode(addr[w*32 +: 32]);
         if (q.size() < MO) begin
            if (sel < 0 || dgnt[sel]) e_gnt[w] = 1'b1;
            if (sel >= 0) begin
               e_dreq[sel] = 1'b1;
               e_daddr[sel*32 +: 32] = addr[w*32 +: 32];
               e_dwe[sel] = we[w];
               e_dbe[sel*4 +: 4] = be[w*4 +: 4];
               e_dwdata[sel*32 +: 32] = wdata[w*32 +: 32];
            end
         end
      end
      if (q.size() > 0) begin
         ent = q[0];
         if (ent.miss) begin
            e_rv[ent.host] = 1'b1;
            e_err[ent.host] = 1'b1;
            popped = 1'b1;
         end else if (drv[ent.dev]) begin
            e_rv[ent.host] = 1'b1;
            e_err[ent.host] = derr[ent.dev];
            e_rdata[ent.host*32 +: 32] = drdata[ent.dev*32 +: 32];
            popped = 1'b1;
         end
      end
      chk("gnt", gnt, e_gnt);
      chk("rvalid", rvalid, e_rv);
      chk("rdata", rdata, e_rdata);
      chk("err", err, e_err);
      chk("dreq", dreq, e_dreq);
      chk("daddr", daddr, e_daddr);
      chk("dwe", dwe, e_dwe);
      chk("dbe", dbe, e_dbe);
      chk("dwdata", dwdata, e_dwdata);
      chk("outstanding", outstanding, 64'(q.size()));
      s_gnt = gnt; s_rv = rvalid; s_err = err; s_dreq = dreq; s_rdata = rdata; s_out = outstanding;
      @(posedge clk);
      if (popped) void'(q.pop_front());
      if (e_gnt != 0) begin
         nent.host = w;
         nent.dev  = sel;
         nent.miss = (sel < 0);
         q.push_back(nent);
`ifdef BUS_RR_ARB_EN
         m_ptr = (w + 1) % NH;
`endif
      end
      #1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      req = 2'b11; addr = {32'h0010_0000, 32'h0000_0000}; dgnt = 2'b11; drv = 2'b11;
      #3;
      chk_zero("reset");
      @(posedge clk); #1;
      idle();
      rst_n = 1'b1;
      model_reset();

      // Single read through dev0
      host_set(0, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
      dgnt = 2'b01;
      cycle();
      chk("single_gnt", s_gnt, 2'b01);
      chk("single_out0", s_out, 0);
      idle();
      cycle();
      chk("single_out1", s_out, 1);
      cycle();
      drv = 2'b01; drdata = {32'h0, 32'hDEAD_BEEF};
      cycle();
      chk("single_rvalid", s_rv, 2'b01);
      chk("single_rdata", s_rdata, 64'hDEAD_BEEF);
      idle();
      cycle();
      chk("single_out_end", s_out, 0);

      // Decode miss
      host_set(1, 32'h8000_0000, 1'b0, 4'hF, 32'h0);
      cycle();
      chk("miss_gnt", s_gnt, 2'b10);
      chk("miss_dreq", s_dreq, 0);
      idle();
      cycle();
      chk("miss_rvalid", s_rv, 2'b10);
      chk("miss_err", s_err, 2'b10);
      chk("miss_rdata", s_rdata, 0);

      // Back-pressure and full
      for (int k = 0; k < 4; k++) begin
         idle();
         host_set(0, 32'h0010_0000 + 32'(k * 4), 1'b1, 4'h3, 32'h1000 + 32'(k));
         dgnt = 2'b10;
         cycle();
         chk("full_fill_gnt", s_gnt, 2'b01);
      end
      host_set(0, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
      cycle();
      chk("full_out", s_out, 4);
      chk("full_gnt", s_gnt, 0);
      chk("full_dreq", s_dreq, 0);
      drv = 2'b10; drdata = {32'h0000_1111, 32'h0};
      cycle();
      chk("full_pop_rvalid", s_rv, 2'b01);
      chk("full_pop_gnt", s_gnt, 0);
      drv = 2'b00;
      cycle();
      chk("full_after_gnt", s_gnt, 2'b01);
      idle();
      drv = 2'b10;
      for (int k = 0; k < 4; k++) cycle();
      idle();
      cycle();
      chk("full_drained", s_out, 0);

      // In-order routing across hosts and devices
      host_set(0, 32'h0010_0080, 1'b0, 4'hF, 32'h0);
      dgnt = 2'b10;
      cycle();
      chk("order_gnt0", s_gnt, 2'b01);
      idle();
      host_set(1, 32'h0000_0020, 1'b0, 4'hF, 32'h0);
      dgnt = 2'b01;
      cycle();
      chk("order_gnt1", s_gnt, 2'b10);
      idle();
      drv = 2'b01; drdata = {32'h0, 32'hAAAA_0000};
      cycle();
      chk("order_early_ignored", s_rv, 0);
      drv = 2'b10; drdata = {32'hBBBB_1111, 32'h0};
      cycle();
      chk("order_first_host0", s_rv, 2'b01);
      chk("order_first_data", s_rdata, 64'hBBBB_1111);
      drv = 2'b01; drdata = {32'h0, 32'hCCCC_2222};
      cycle();
      chk("order_second_host1", s_rv, 2'b10);
      chk("order_second_data", s_rdata, {32'hCCCC_2222, 32'h0});

      // Reset with two transactions in flight
      idle();
      host_set(0, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
      dgnt = 2'b10;
      cycle();
      host_set(0, 32'h0010_0004, 1'b0, 4'hF, 32'h0);
      cycle();
      chk("midrst_pre_out", outstanding, 2);
      idle();
      host_set(0, 32'h0000_0100, 1'b1, 4'hF, 32'h5555_5555);
      dgnt = 2'b01; drv = 2'b10; drdata = {32'h7777_7777, 32'h0};
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      model_reset();
      @(posedge clk); #1;
      idle();
      #1;
      rst_n = 1'b1;
      drv = 2'b11; drdata = {32'h1234_5678, 32'h9ABC_DEF0};
      cycle();
      chk("late_rvalid", s_rv, 0);
      chk("late_out", s_out, 0);

      // Both hosts requesting continuously
      idle();
      host_set(0, 32'h0000_0200, 1'b0, 4'hF, 32'h0);
      host_set(1, 32'h0000_0300, 1'b0, 4'hF, 32'h0);
      dgnt = 2'b01; drv = 2'b01;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] exp_g;
`ifdef BUS_RR_ARB_EN
         exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
         exp_g = 2'b01;
`endif
         drdata = {32'h0, 32'(k)};
         cycle();
         chk("arb_gnt", s_gnt, exp_g);
      end
      idle();
      drv = 2'b01;
      cycle();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int h = 0; h < NH; h++) begin
            logic [31:0] a;
            case ($urandom_range(0, 2))
               0: a = {12'h000, 20'($urandom)};
               1: a = {12'h001, 20'($urandom)};
               default: a = {1'b1, 31'($urandom)};
            endcase
            if ($urandom_range(0, 1) == 1) host_set(h, a, 1'($urandom), 4'($urandom), $urandom);
         end
         dgnt = 2'($urandom);
         drv = 2'($urandom);
         derr = 2'($urandom);
         drdata = {$urandom, $urandom};
         cycle();
      end
      idle();
      drv = 2'b11;
      for (int k = 0; k < 6; k++) cycle();
      chk("final_out", s_out, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bus_arb_ooo.md
Name: bus_arb_ooo

Overview:
- Next-generation parametrised host/device interconnect for the Ibex-style simulation system.
- Adds over the existing single-cycle bus:
  - a device-side grant handshake;
  - variable-latency, in-order responses with up to MaxOutstanding transactions in flight;
  - a built-in decode-error responder;
  - optional round-robin host arbitration.
- Sits between the core's instruction/data ports (hosts) and RAM/timer/peripheral devices.

Parameters:
- NrHosts, 2: number of host ports (1..8).
- NrDevices, 2: number of device ports (1..16).
- DataWidth, 32: data bus width; multiple of 8.
- AddressWidth, 32: address width.
- MaxOutstanding, 4: depth of the response-tracking FIFO; power of two, >=2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- host_req_i  in  NrHosts  per-host request.
- host_gnt_o  out  NrHosts  per-host grant; a request is accepted in the cycle req&gnt.
- host_addr_i  in  NrHosts*AddressWidth  packed per-host address.
- host_we_i  in  NrHosts  write enable.
- host_be_i  in  NrHosts*DataWidth/8  byte enables.
- host_wdata_i  in  NrHosts*DataWidth  write data.
- host_rvalid_o  out  NrHosts  response valid.
- host_rdata_o  out  NrHosts*DataWidth  response data.
- host_err_o  out  NrHosts  response error.
- device_req_o  out  NrDevices  device request.
- device_gnt_i  in  NrDevices  device accepts request.
- device_addr_o, device_we_o, device_be_o, device_wdata_o  out  packed per-device  forwarded request fields.
- device_rvalid_i  in  NrDevices  device response valid.
- device_rdata_i  in  NrDevices*DataWidth  device response data.
- device_err_i  in  NrDevices  device response error.
- cfg_device_addr_base  in  NrDevices*AddressWidth  device base address.
- cfg_device_addr_mask  in  NrDevices*AddressWidth  device address mask.
- outstanding_o  out  $clog2(MaxOutstanding)+1  in-flight transaction count.

Behaviour:
- Reset (rst_ni=0, asynchronous): FIFO pointers and count cleared; RR pointer set to 0. While reset is asserted, all outputs are forced to 0. Transactions in flight at reset are dropped: no response is produced for them after reset release.
- Arbitration (combinational): one winner among asserted host_req_i. Default is fixed priority, lowest index wins.
- Decode (combinational): the winner's address is matched against each device with (addr & mask) == base. The lowest matching index wins. No match is a decode miss.
- Forwarding:
  - Condition: winner exists, decode hit, FIFO not full.
  - Selected device: device_req_o=1; address, we, be and wdata are copied from the winner.
  - All other devices: every field is 0.
- Grant:
  - host_gnt_o[winner] = !full & (miss | device_gnt_i[sel]); all other grants are 0.
  - Full blocks a push even when a pop occurs in the same cycle.
- Push: on an accepted request, write {host idx, device idx, miss flag} to the tail and increment the count.
- Response path, head entry {h,d,m}:
  - m=0: when device_rvalid_i[d]=1, drive host h with rvalid=1, rdata=device_rdata_i[d], err=device_err_i[d], and pop.
  - m=1: in the first cycle the entry is at the head, drive host h with rvalid=1, err=1, rdata=0, and pop. Minimum latency is 1 cycle after the grant.
  - rvalid from any device other than the head's device is ignored.
  - All non-target host response outputs are 0.
  - FIFO empty: no host rvalid.
- Push and pop may occur in the same cycle; the count is unchanged. Responses are strictly in acceptance order across all hosts.
- outstanding_o = FIFO count, registered.

Optional Feature:
- Macro: BUS_RR_ARB_EN.
- Defined: round-robin arbitration.
  - Search starts at the RR pointer, wrapping modulo NrHosts.
  - On each host grant, the pointer becomes (granted+1) mod NrHosts.
  - The pointer does not move when nothing is granted.
- Undefined: fixed priority; the pointer register is absent.

Test Plan:
- Setup for all cases:
  - Parameters: NrHosts=2, NrDevices=2, MaxOutstanding=4.
  - dev0: base 0x0000_0000, mask 0xFFF0_0000.
  - dev1: base 0x0010_0000, mask 0xFFF0_0000.
- Single read: host0 reads 0x0000_0010; dev0 gnt in the same cycle, rvalid 3 cycles later with rdata 0xDEAD_BEEF -> host0 gnt=1 that cycle; host0 rvalid=1, rdata=0xDEAD_BEEF exactly when dev0 rvalid; outstanding_o goes 0->1->0.
- Decode miss: host1 reads 0x8000_0000 -> host1 gnt=1 immediately, no device_req; next cycle host1 rvalid=1, err=1, rdata=0.
- Back-pressure and full:
  - Stimulus: 4 accepted requests to dev1 with no rvalid, then a 5th request.
  - Required: outstanding_o=4 and host gnt=0 for the 5th.
  - Stimulus: dev1 rvalid once.
  - Required: the 5th request is still blocked in that cycle and is granted the following cycle.
- In-order routing: host0->dev1 accepted, then host1->dev0 accepted; dev0 rvalid first (ignored), dev1 rvalid, then dev0 rvalid -> host0 responds first, host1 responds second; no response while dev0's early rvalid is ignored.
- Arbitration, both hosts requesting continuously:
  - Without BUS_RR_ARB_EN: host0 wins every cycle.
  - With BUS_RR_ARB_EN: grants alternate 0,1,0,1.
- Reset mid-flight: 2 outstanding, assert rst_ni=0 asynchronously mid-cycle -> all outputs 0 immediately; after release outstanding_o=0 and late device rvalid produces no host rvalid.
